// File: rtl/mult_driver.sv
// Host-side driver for an external complex multiplier: queues operand words and
// result words in two small FIFOs and runs one multiply at a time over valid/ready.
module mult_driver #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        sw_rst,
    input  logic        in_push,
    input  logic [31:0] in_data,
    output logic        in_full,
    input  logic        out_pop,
    output logic [33:0] out_data,
    output logic        out_empty,
    output logic        op_val,
    input  logic        op_ready,
    output logic [31:0] op_data,
    input  logic        res_val,
    output logic        res_ready,
    input  logic [33:0] res_data,
    output logic [7:0]  done_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        WAIT_RES = 2'd2
    } state_t;

    state_t      r_state;
    logic [7:0]  r_done_cnt;

    logic [31:0]   r_op_mem [DEPTH];
    logic [AW-1:0] r_op_wr;
    logic [AW-1:0] r_op_rd;
    logic [CW-1:0] r_op_cnt;

    logic [33:0]   r_res_mem [DEPTH];
    logic [AW-1:0] r_res_wr;
    logic [AW-1:0] r_res_rd;
    logic [CW-1:0] r_res_cnt;

    logic w_op_empty;
    logic w_res_full;
    logic w_op_push;
    logic w_op_pop;
    logic w_res_push;
    logic w_res_pop;

    assign in_full    = (r_op_cnt == CNT_FULL);
    assign w_op_empty = (r_op_cnt == '0);
    assign w_res_full = (r_res_cnt == CNT_FULL);
    assign out_empty  = (r_res_cnt == '0);
    assign out_data   = r_res_mem[r_res_rd];

    // A push into a full FIFO is dropped even if a pop frees a slot in the same cycle.
    assign w_op_push  = in_push && !in_full;
    assign w_op_pop   = (r_state == SEND) && op_ready;
    assign w_res_push = (r_state == WAIT_RES) && res_val;
    assign w_res_pop  = out_pop && !out_empty;

    assign op_val    = (r_state == SEND);
    assign res_ready = (r_state == WAIT_RES);
    assign op_data   = op_val ? r_op_mem[r_op_rd] : '0;
    assign done_cnt  = r_done_cnt;

    // NOTE: storage arrays carry no reset; the pointers and counts alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_op_push) r_op_mem[r_op_wr] <= in_data;
        if (w_res_push) r_res_mem[r_res_wr] <= res_data;
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_op_wr   <= '0;
            r_op_rd   <= '0;
            r_op_cnt  <= '0;
            r_res_wr  <= '0;
            r_res_rd  <= '0;
            r_res_cnt <= '0;
        end else if (sw_rst) begin
            r_op_wr   <= '0;
            r_op_rd   <= '0;
            r_op_cnt  <= '0;
            r_res_wr  <= '0;
            r_res_rd  <= '0;
            r_res_cnt <= '0;
        end else begin
            if (w_op_push) r_op_wr <= r_op_wr + PTR_ONE;
            if (w_op_pop)  r_op_rd <= r_op_rd + PTR_ONE;
            if (w_op_push && !w_op_pop)      r_op_cnt <= r_op_cnt + CNT_ONE;
            else if (!w_op_push && w_op_pop) r_op_cnt <= r_op_cnt - CNT_ONE;

            if (w_res_push) r_res_wr <= r_res_wr + PTR_ONE;
            if (w_res_pop)  r_res_rd <= r_res_rd + PTR_ONE;
            if (w_res_push && !w_res_pop)      r_res_cnt <= r_res_cnt + CNT_ONE;
            else if (!w_res_push && w_res_pop) r_res_cnt <= r_res_cnt - CNT_ONE;
        end
    end

    // Launch only when a result slot is free, so a returning result can always be stored.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= IDLE;
            r_done_cnt <= '0;
        end else if (sw_rst) begin
            r_state    <= IDLE;
            r_done_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_op_empty && !w_res_full) r_state <= SEND;
                end
                SEND: begin
                    if (op_ready) r_state <= WAIT_RES;
                end
                WAIT_RES: begin
                    if (res_val) begin
                        r_state    <= IDLE;
                        r_done_cnt <= r_done_cnt + 8'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_driver.sv
// Directed bench for mult_driver: the bench plays both the host and the multiplier,
// returning the complex product of each operand word as the result word.
module tb_mult_driver;
    logic        clk = 1'b0;
    logic        rstn;
    logic        sw_rst;
    logic        in_push;
    logic [31:0] in_data;
    logic        in_full;
    logic        out_pop;
    logic [33:0] out_data;
    logic        out_empty;
    logic        op_val;
    logic        op_ready;
    logic [31:0] op_data;
    logic        res_val;
    logic        res_ready;
    logic [33:0] res_data;
    logic [7:0]  done_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mult_driver #(.DEPTH(4)) dut (
        .clk(clk), .rstn(rstn), .sw_rst(sw_rst),
        .in_push(in_push), .in_data(in_data), .in_full(in_full),
        .out_pop(out_pop), .out_data(out_data), .out_empty(out_empty),
        .op_val(op_val), .op_ready(op_ready), .op_data(op_data),
        .res_val(res_val), .res_ready(res_ready), .res_data(res_data),
        .done_cnt(done_cnt)
    );

    function automatic logic [33:0] cmul(input logic [31:0] w);
        logic signed [16:0] ar, ai, br, bi, re, im;
        ar = {{9{w[31]}}, w[31:24]};
        ai = {{9{w[23]}}, w[23:16]};
        br = {{9{w[15]}}, w[15:8]};
        bi = {{9{w[7]}},  w[7:0]};
        re = ar * br - ai * bi;
        im = ar * bi + ai * br;
        return {re, im};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        in_push = 1'b1;
        in_data = w;
        tick();
        in_push = 1'b0;
    endtask

    task automatic wait_send();
        for (int i = 0; i < 64 && op_val !== 1'b1; i++) tick();
        checks++;
        if (op_val !== 1'b1) begin
            failures++;
            $display("FAIL send_timeout: op_val=%b required 1", op_val);
        end
    endtask

    // Plays the multiplier: accepts the next operand and returns its product one cycle later.
    task automatic serve(input logic pop_at_res, output logic [31:0] got);
        wait_send();
        got      = op_data;
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;
        res_val  = 1'b1;
        res_data = cmul(got);
        out_pop  = pop_at_res;
        tick();
        res_val  = 1'b0;
        res_data = '0;
        out_pop  = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; sw_rst = 1'b0; in_push = 1'b0; in_data = '0;
        out_pop = 1'b0; op_ready = 1'b0; res_val = 1'b0; res_data = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({op_val, res_ready, in_full, out_empty} !== 4'b0001) begin
            failures++;
            $display("FAIL reset_flags: {op_val,res_ready,in_full,out_empty}=%b required 0001",
                     {op_val, res_ready, in_full, out_empty});
        end
        checks++;
        if (op_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_op_data: got %h required 0", op_data);
        end
        checks++;
        if (done_cnt !== 8'd0) begin
            failures++;
            $display("FAIL reset_done_cnt: got %0d required 0", done_cnt);
        end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_single();
        op_ready = 1'b1;
        push(32'h0102_0304);
        checks++;
        if (op_val !== 1'b0) begin
            failures++;
            $display("FAIL single_op_val_early: got %b required 0", op_val);
        end
        tick();
        checks++;
        if ({op_val, op_data} !== {1'b1, 32'h0102_0304}) begin
            failures++;
            $display("FAIL single_send: op_val=%b op_data=%h required 1 01020304", op_val, op_data);
        end
        tick();
        op_ready = 1'b0;
        checks++;
        if ({op_val, res_ready} !== 2'b01) begin
            failures++;
            $display("FAIL single_wait: op_val=%b res_ready=%b required 0 1", op_val, res_ready);
        end
        res_val  = 1'b1;
        res_data = 34'h0_0000_000A;
        tick();
        res_val  = 1'b0;
        checks++;
        if ({res_ready, out_empty, out_data, done_cnt} !== {1'b0, 1'b0, 34'h0_0000_000A, 8'd1}) begin
            failures++;
            $display("FAIL single_result: res_ready=%b out_empty=%b out_data=%h done_cnt=%0d required 0 0 00000000a 1",
                     res_ready, out_empty, out_data, done_cnt);
        end
        out_pop = 1'b1;
        tick();
        out_pop = 1'b0;
        checks++;
        if (out_empty !== 1'b1) begin
            failures++;
            $display("FAIL single_pop_empty: got %b required 1", out_empty);
        end
    endtask

    task automatic test_full_drop();
        logic [31:0] w [5] = '{32'h7F80_FF01, 32'h8080_8080, 32'hFF01_FE02, 32'h1020_3040, 32'hDEAD_BEEF};
        logic [31:0] got;
        op_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push(w[i]);
            checks++;
            if (in_full !== (i >= 3)) begin
                failures++;
                $display("FAIL drop_in_full_%0d: got %b required %b", i, in_full, (i >= 3));
            end
        end
        for (int i = 0; i < 4; i++) begin
            serve(1'b0, got);
            checks++;
            if (got !== w[i]) begin
                failures++;
                $display("FAIL drop_order_%0d: op_data=%h required %h", i, got, w[i]);
            end
        end
        repeat (3) tick();
        checks++;
        if ({op_val, done_cnt} !== {1'b0, 8'd5}) begin
            failures++;
            $display("FAIL drop_no_fifth: op_val=%b done_cnt=%0d required 0 5", op_val, done_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_data !== cmul(w[i])) begin
                failures++;
                $display("FAIL drop_result_%0d: got %h required %h", i, out_data, cmul(w[i]));
            end
            out_pop = 1'b1;
            tick();
            out_pop = 1'b0;
        end
        checks++;
        if (out_empty !== 1'b1) begin
            failures++;
            $display("FAIL drop_drained: out_empty=%b required 1", out_empty);
        end
    endtask

    task automatic test_hold();
        logic [31:0] h = 32'h05FB_0A81;
        push(h);
        wait_send();
        op_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if ({op_val, op_data} !== {1'b1, h}) begin
                failures++;
                $display("FAIL hold_stable_%0d: op_val=%b op_data=%h required 1 %h", i, op_val, op_data, h);
            end
        end
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;
        checks++;
        if ({op_val, res_ready} !== 2'b01) begin
            failures++;
            $display("FAIL hold_transfer: op_val=%b res_ready=%b required 0 1", op_val, res_ready);
        end
        res_val  = 1'b1;
        res_data = cmul(h);
        tick();
        res_val  = 1'b0;
        checks++;
        if (out_data !== cmul(h)) begin
            failures++;
            $display("FAIL hold_result: got %h required %h", out_data, cmul(h));
        end
        out_pop = 1'b1;
        tick();
        out_pop = 1'b0;
    endtask

    task automatic test_res_full();
        logic [31:0] v [5] = '{32'h0101_0101, 32'h0202_0303, 32'hFFFF_FFFF, 32'h7F7F_8080, 32'h1234_5678};
        logic [31:0] got [5];
        op_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(v[i]);
        serve(1'b0, got[0]);
        push(v[4]);
        for (int i = 1; i < 4; i++) serve(1'b0, got[i]);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got[i] !== v[i]) begin
                failures++;
                $display("FAIL rfull_order_%0d: op_data=%h required %h", i, got[i], v[i]);
            end
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (op_val !== 1'b0) begin
                failures++;
                $display("FAIL rfull_stall_%0d: op_val=%b required 0", k, op_val);
            end
            tick();
        end
        checks++;
        if (out_data !== cmul(v[0])) begin
            failures++;
            $display("FAIL rfull_head: got %h required %h", out_data, cmul(v[0]));
        end
        out_pop = 1'b1;
        tick();
        out_pop = 1'b0;
        checks++;
        if (op_val !== 1'b0) begin
            failures++;
            $display("FAIL rfull_pop_edge: op_val=%b required 0", op_val);
        end
        tick();
        checks++;
        if ({op_val, op_data} !== {1'b1, v[4]}) begin
            failures++;
            $display("FAIL rfull_launch: op_val=%b op_data=%h required 1 %h", op_val, op_data, v[4]);
        end
        serve(1'b0, got[4]);
        for (int i = 1; i < 5; i++) begin
            checks++;
            if (out_data !== cmul(v[i])) begin
                failures++;
                $display("FAIL rfull_result_%0d: got %h required %h", i, out_data, cmul(v[i]));
            end
            out_pop = 1'b1;
            tick();
            out_pop = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] x [4] = '{32'h0A0B_0C0D, 32'hF0F1_F2F3, 32'h4000_C000, 32'h0180_7F01};
        logic [31:0] exp_rest [3];
        logic [31:0] xd = 32'hBAD0_BAD0;
        logic [31:0] y  = 32'h1122_3344;
        logic [31:0] got;
        exp_rest = '{x[2], x[3], y};
        op_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(x[i]);
        checks++;
        if (in_full !== 1'b1) begin
            failures++;
            $display("FAIL b2b_full: in_full=%b required 1", in_full);
        end
        op_ready = 1'b1; in_push = 1'b1; in_data = xd;
        tick();
        op_ready = 1'b0; in_push = 1'b0;
        checks++;
        if ({in_full, res_ready} !== 2'b01) begin
            failures++;
            $display("FAIL b2b_drop: in_full=%b res_ready=%b required 0 1", in_full, res_ready);
        end
        res_val = 1'b1; res_data = cmul(x[0]);
        tick();
        res_val = 1'b0;
        wait_send();
        checks++;
        if (op_data !== x[1]) begin
            failures++;
            $display("FAIL b2b_second: op_data=%h required %h", op_data, x[1]);
        end
        op_ready = 1'b1; in_push = 1'b1; in_data = y;
        tick();
        op_ready = 1'b0; in_push = 1'b0;
        res_val = 1'b1; res_data = cmul(x[1]); out_pop = 1'b1;
        tick();
        res_val = 1'b0; out_pop = 1'b0;
        checks++;
        if ({out_empty, out_data} !== {1'b0, cmul(x[1])}) begin
            failures++;
            $display("FAIL b2b_write_pop: out_empty=%b out_data=%h required 0 %h", out_empty, out_data, cmul(x[1]));
        end
        for (int j = 0; j < 3; j++) begin
            serve(1'b1, got);
            checks++;
            if ({got, out_data} !== {exp_rest[j], cmul(exp_rest[j])}) begin
                failures++;
                $display("FAIL b2b_rest_%0d: op_data=%h out_data=%h required %h %h",
                         j, got, out_data, exp_rest[j], cmul(exp_rest[j]));
            end
        end
        repeat (4) tick();
        checks++;
        if ({op_val, done_cnt} !== {1'b0, 8'd16}) begin
            failures++;
            $display("FAIL b2b_end: op_val=%b done_cnt=%0d required 0 16", op_val, done_cnt);
        end
        out_pop = 1'b1;
        tick();
        out_pop = 1'b0;
    endtask

    task automatic test_sw_rst();
        logic [31:0] got;
        push(32'h0303_0303);
        serve(1'b0, got);
        op_ready = 1'b0;
        push(32'h0404_0404);
        push(32'h0505_0505);
        push(32'h0606_0606);
        wait_send();
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;
        checks++;
        if ({res_ready, out_empty} !== 2'b10) begin
            failures++;
            $display("FAIL swrst_pre: res_ready=%b out_empty=%b required 1 0", res_ready, out_empty);
        end
        sw_rst = 1'b1; res_val = 1'b1; res_data = cmul(32'h0404_0404);
        tick();
        sw_rst = 1'b0; res_val = 1'b0;
        checks++;
        if ({op_val, res_ready, in_full, out_empty, done_cnt} !== {4'b0001, 8'd0}) begin
            failures++;
            $display("FAIL swrst_state: {op_val,res_ready,in_full,out_empty}=%b done_cnt=%0d required 0001 0",
                     {op_val, res_ready, in_full, out_empty}, done_cnt);
        end
        repeat (3) tick();
        checks++;
        if ({op_val, out_empty} !== 2'b01) begin
            failures++;
            $display("FAIL swrst_flushed: op_val=%b out_empty=%b required 0 1", op_val, out_empty);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] got;
        push(32'h0707_0707);
        serve(1'b0, got);
        push(32'h0808_0808);
        wait_send();
        rstn = 1'b0;
        #2;
        checks++;
        if ({op_val, res_ready, in_full, out_empty} !== 4'b0001) begin
            failures++;
            $display("FAIL arst_flags: {op_val,res_ready,in_full,out_empty}=%b required 0001",
                     {op_val, res_ready, in_full, out_empty});
        end
        checks++;
        if ({op_data, done_cnt} !== {32'h0, 8'd0}) begin
            failures++;
            $display("FAIL arst_values: op_data=%h done_cnt=%0d required 0 0", op_data, done_cnt);
        end
        rstn = 1'b1;
        repeat (3) tick();
        checks++;
        if (op_val !== 1'b0) begin
            failures++;
            $display("FAIL arst_abandoned: op_val=%b required 0", op_val);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] w;
        logic [31:0] prev = '0;
        logic [31:0] got;
        logic [7:0]  b;
        for (int i = 0; i < 256; i++) begin
            b = 8'(i);
            w = {b, ~b, b ^ 8'h5A, 8'h33};
            push(w);
            if (i > 0) begin
                checks++;
                if (out_data !== cmul(prev)) begin
                    failures++;
                    $display("FAIL wrap_prev_%0d: got %h required %h", i, out_data, cmul(prev));
                end
            end
            serve(i > 0, got);
            checks++;
            if ({got, out_empty, out_data} !== {w, 1'b0, cmul(w)}) begin
                failures++;
                $display("FAIL wrap_op_%0d: op_data=%h out_empty=%b out_data=%h required %h 0 %h",
                         i, got, out_empty, out_data, w, cmul(w));
            end
            if (i == 254) begin
                checks++;
                if (done_cnt !== 8'd255) begin
                    failures++;
                    $display("FAIL wrap_255: done_cnt=%0d required 255", done_cnt);
                end
            end
            prev = w;
        end
        checks++;
        if (done_cnt !== 8'd0) begin
            failures++;
            $display("FAIL wrap_zero: done_cnt=%0d required 0", done_cnt);
        end
        out_pop = 1'b1;
        tick();
        out_pop = 1'b0;
        checks++;
        if (out_empty !== 1'b1) begin
            failures++;
            $display("FAIL wrap_drained: out_empty=%b required 1", out_empty);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_full_drop();
        test_hold();
        test_res_full();
        test_back_to_back();
        test_sw_rst();
        test_async_reset();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mult_driver.md
MULT_DRIVER -- requirements
Module: mult_driver

Interface
REQ-001 Parameter: DEPTH, default 4, entry count of each internal FIFO (operand and result); power of two, at least 2.
REQ-002 Port: clk  input  1  single clock, all state on rising edge.
REQ-003 Port: rstn  input  1  reset, asynchronous, active-low.
REQ-004 Port: sw_rst  input  1  software reset, synchronous, active-high; the same sw_rst net drives the attached multiplier.
REQ-005 Port: in_push  input  1  host writes one operand word this cycle.
REQ-006 Port: in_data  input  32  operand word {ar[31:24], ai[23:16], br[15:8], bi[7:0]}, each field signed two's complement.
REQ-007 Port: in_full  output  1  operand FIFO holds DEPTH entries.
REQ-008 Port: out_pop  input  1  host reads one result word this cycle.
REQ-009 Port: out_data  output  34  head of result FIFO {re[33:17], im[16:0]}; held stable while out_empty=0 and out_pop=0.
REQ-010 Port: out_empty  output  1  result FIFO holds zero entries.
REQ-011 Port: op_val  output  1  operand valid toward multiplier.
REQ-012 Port: op_ready  input  1  multiplier accepts operands.
REQ-013 Port: op_data  output  32  operand word toward multiplier.
REQ-014 Port: res_val  input  1  multiplier result valid.
REQ-015 Port: res_ready  output  1  driver accepts result.
REQ-016 Port: res_data  input  34  multiplier result word.
REQ-017 Port: done_cnt  output  8  count of results stored in the result FIFO since reset; wraps 255->0.

Function
REQ-018 Operand transfer SHALL occur on a rising edge where op_val=1 and op_ready=1; result transfer on a rising edge where res_val=1 and res_ready=1.
REQ-019 The FSM SHALL have states IDLE, SEND, WAIT_RES; at most one operation outstanding.
REQ-020 IDLE->SEND when operand FIFO is non-empty and result FIFO is not full; otherwise remain in IDLE.
REQ-021 SEND: op_val=1, op_data = operand FIFO head; on operand transfer, pop operand FIFO and go to WAIT_RES; otherwise remain, with op_val and op_data held.
REQ-022 WAIT_RES: res_ready=1; on result transfer, write res_data into result FIFO, increment done_cnt, go to IDLE.
REQ-023 op_val SHALL be 0 outside SEND, and res_ready SHALL be 0 outside WAIT_RES; both are decoded from the registered state.
REQ-024 Minimum turnaround: the transfer edge of one operation to op_val=1 for the next is 2 cycles (WAIT_RES->IDLE->SEND).
REQ-025 A push when in_full=1 SHALL be dropped, even if a pop of that FIFO occurs the same cycle; the FIFO is unchanged by the dropped push.
REQ-026 out_pop when out_empty=1 SHALL be ignored; out_data is then don't-care.
REQ-027 A host push and an internal pop of the operand FIFO in the same cycle (not full) SHALL both take effect, leaving count unchanged.
REQ-028 Likewise, an internal write and a host pop of the result FIFO in the same cycle SHALL both take effect, leaving count unchanged.
REQ-029 FIFO pointers SHALL wrap modulo DEPTH; FIFOs preserve order with no loss or duplication.
REQ-030 in_full, out_empty and out_data SHALL be registered or decoded from registered state only (no combinational input-to-output path).

Reset
REQ-031 rstn=0 SHALL asynchronously set state=IDLE, both FIFOs empty and done_cnt=0, giving op_val=0, res_ready=0, in_full=0, out_empty=1 and op_data=0.
REQ-032 sw_rst=1 at a rising edge SHALL apply the REQ-031 values synchronously; it takes priority over push, pop and transfers that cycle.
REQ-033 sw_rst or rstn asserted in SEND or WAIT_RES SHALL abandon the in-flight operation; no result is stored for it.

Verification
REQ-034 Push 0x01020304 while op_ready is held at 1 and res_val is returned 1 cycle after the transfer with 0x0_0000_000A -> op_val rises 1 cycle after the push, out_empty falls, out_data=0x000A, done_cnt=1.
REQ-035 Push 5 words with DEPTH=4 and op_ready=0 -> in_full=1 after the 4th push (SEND has not yet popped); the 5th is dropped; exactly 4 results return later, in order.
REQ-036 Hold op_ready=0 for 10 cycles in SEND -> op_val stays 1 and op_data stays stable; transfer then occurs on the first edge with op_ready=1.
REQ-037 Fill the result FIFO (4 results, no out_pop) while operands remain queued -> FSM stays in IDLE with op_val=0; one out_pop -> next operation launches.
REQ-038 sw_rst pulse in WAIT_RES with 2 queued operands -> next cycle IDLE, in_full=0, out_empty=1, done_cnt=0, res_ready=0.
REQ-039 Issue 256 operations -> done_cnt wraps to 0.
